// File: rtl/pc_sequencer.sv
// Program counter with branch/jump targets and a circular return-address stack.
// Define PC_SEQ_TRACE_EN to add the prev_pc and redirect_cnt trace outputs.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned IMM_WIDTH   = 32,
    parameter int unsigned JADDR_WIDTH = 26,
    parameter int unsigned RAS_DEPTH   = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch,
    input  logic                   zero,
    input  logic [IMM_WIDTH-1:0]   imm,
    input  logic                   jump,
    input  logic                   jal,
    input  logic                   ret,
    input  logic [JADDR_WIDTH-1:0] jump_addr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    link_addr,
    output logic                   ras_empty,
    output logic                   ras_full,
    output logic                   ras_ovf,
`ifdef PC_SEQ_TRACE_EN
    output logic                   ras_unf,
    output logic [PC_WIDTH-1:0]    prev_pc,
    output logic [15:0]            redirect_cnt
`else
    output logic                   ras_unf
`endif
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_inc;
    logic [PW-1:0]       ptr_dec;
    logic [CW-1:0]       count;

    logic [PC_WIDTH-1:0] seq;
    logic [PC_WIDTH-1:0] br;
    logic [PC_WIDTH-1:0] jt;
    logic [PC_WIDTH-1:0] rt;
    logic [PC_WIDTH-1:0] pc_next;
    logic                push;
    logic                pop;
    logic                replace;
    logic                set_unf;

    assign seq       = pc + 1'b1;
    assign br        = seq + imm[PC_WIDTH-1:0];
    assign jt        = jump_addr[PC_WIDTH-1:0];
    assign rt        = ras_mem[ptr];
    assign ptr_inc   = ptr + 1'b1;
    assign ptr_dec   = ptr - 1'b1;
    assign link_addr = seq;
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));

    always_comb begin
        pc_next = seq;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        set_unf = 1'b0;
        if (ret) begin
            // ret+jal on a live stack swaps the top in place; on an empty stack it degrades to a push.
            if (count == '0) begin
                set_unf = 1'b1;
                push    = jal;
            end else begin
                pc_next = rt;
                replace = jal;
                pop     = ~jal;
            end
        end else if (jump || jal) begin
            pc_next = jt;
            push    = jal;
        end else if (branch && zero) begin
            pc_next = br;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ptr     <= '0;
            count   <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (!stall) begin
            pc <= pc_next;
            if (set_unf) begin
                ras_unf <= 1'b1;
            end
            if (push) begin
                ptr              <= ptr_inc;
                ras_mem[ptr_inc] <= seq;
                if (count == CW'(RAS_DEPTH)) begin
                    ras_ovf <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (pop) begin
                ptr   <= ptr_dec;
                count <= count - 1'b1;
            end
            if (replace) begin
                ras_mem[ptr] <= seq;
            end
        end
    end

`ifdef PC_SEQ_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_pc      <= RESET_PC;
            redirect_cnt <= '0;
        end else if (!stall) begin
            prev_pc <= pc;
            if (pc_next != seq) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] imm;
    logic        jump;
    logic        jal;
    logic        ret;
    logic [25:0] jump_addr;
    logic [7:0]  pc;
    logic [7:0]  link_addr;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;
`ifdef PC_SEQ_TRACE_EN
    logic [7:0]  prev_pc;
    logic [15:0] redirect_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(
        .PC_WIDTH(8),
        .IMM_WIDTH(32),
        .JADDR_WIDTH(26),
        .RAS_DEPTH(4),
        .RESET_PC(8'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch(branch),
        .zero(zero),
        .imm(imm),
        .jump(jump),
        .jal(jal),
        .ret(ret),
        .jump_addr(jump_addr),
        .pc(pc),
        .link_addr(link_addr),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_ovf(ras_ovf),
`ifdef PC_SEQ_TRACE_EN
        .ras_unf(ras_unf),
        .prev_pc(prev_pc),
        .redirect_cnt(redirect_cnt)
`else
        .ras_unf(ras_unf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch = 0; zero = 0; imm = '0;
        jump = 0; jal = 0; ret = 0; jump_addr = '0;
    endtask

    task automatic do_jump(input logic [25:0] a);
        idle(); jump = 1; jump_addr = a; step(); idle();
    endtask

    task automatic do_jal(input logic [25:0] a);
        idle(); jal = 1; jump_addr = a; step(); idle();
    endtask

    task automatic do_ret();
        idle(); ret = 1; step(); idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        step();
        check("rst_pc", pc, 8'h00);
        check("rst_empty", ras_empty, 1);
        check("rst_full", ras_full, 0);
        check("rst_flags", {ras_ovf, ras_unf}, 2'b00);
        rst_n = 1;

        for (int i = 1; i <= 4; i++) begin
            step();
            check("idle_pc", pc, i);
        end
        check("idle_empty", ras_empty, 1);

        step();
        check("pc5", pc, 8'h05);
        branch = 1; zero = 1; imm = 32'hFFFF_FFFD; step(); idle();
        check("br_taken", pc, 8'h03);
        step(); step();
        branch = 1; zero = 0; imm = 32'hFFFF_FFFD; step(); idle();
        check("br_not_taken", pc, 8'h06);

        do_jump(26'h00000FF);
        check("jump_ff", pc, 8'hFF);
        check("link_wrap", link_addr, 8'h00);
        step();
        check("pc_wrap", pc, 8'h00);

        do_jump(26'h001230A);
        check("jump_trunc", pc, 8'h0A);
        check("link_10", link_addr, 8'h0B);
        do_jal(26'h0000040);
        check("jal_pc", pc, 8'h40);
        check("jal_nonempty", ras_empty, 0);
        step(); step();
        check("idle_after_jal", pc, 8'h42);
        do_ret();
        check("ret_pc", pc, 8'h0B);
        check("ret_empty", ras_empty, 1);

        do_jump(26'h1);
        for (int i = 2; i <= 5; i++) do_jal(26'(i));
        check("four_push_full", ras_full, 1);
        check("four_push_ovf", ras_ovf, 0);
        do_jal(26'h6);
        check("fifth_pc", pc, 8'h06);
        check("fifth_ovf", ras_ovf, 1);
        check("fifth_full", ras_full, 1);
        for (int i = 6; i >= 3; i--) begin
            do_ret();
            check("ret_chain", pc, i);
        end
        check("drained_empty", ras_empty, 1);
        check("no_unf_yet", ras_unf, 0);
        do_ret();
        check("unf_pc", pc, 8'h04);
        check("unf_flag", ras_unf, 1);

        idle(); stall = 1; jal = 1; jump_addr = 26'h20; branch = 1; zero = 1; imm = 32'h5;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 8'h04);
            check("stall_ras", {ras_empty, ras_ovf, ras_unf}, 3'b111);
        end
        stall = 0; step(); idle();
        check("unstall_jal", pc, 8'h20);
        check("unstall_push", ras_empty, 0);

        idle(); ret = 1; jal = 1; jump_addr = 26'h30; step(); idle();
        check("retjal_pc", pc, 8'h05);
        check("retjal_count", ras_empty, 0);
        do_ret();
        check("retjal_replaced", pc, 8'h21);
        check("retjal_pop_empty", ras_empty, 1);
        idle(); ret = 1; jal = 1; jump_addr = 26'h30; step(); idle();
        check("retjal_empty_pc", pc, 8'h22);
        check("retjal_empty_push", ras_empty, 0);
        do_ret();
        check("retjal_empty_top", pc, 8'h22);

        idle(); jump = 1; jal = 1; jump_addr = 26'h50; step(); idle();
        check("jump_jal_pc", pc, 8'h50);
        do_jal(26'h60);
        idle(); stall = 1; step();
        check("mid_stall_pc", pc, 8'h60);
        rst_n = 0; jal = 1; jump_addr = 26'h70; step();
        check("stall_rst_pc", pc, 8'h00);
        check("stall_rst_ras", {ras_empty, ras_full, ras_ovf, ras_unf}, 4'b1000);
`ifdef PC_SEQ_TRACE_EN
        check("rst_redirect", redirect_cnt, 0);
        check("rst_prev", prev_pc, 8'h00);
`endif
        rst_n = 1; idle(); step();
        check("post_rst_pc", pc, 8'h01);
`ifdef PC_SEQ_TRACE_EN
        check("post_rst_prev", prev_pc, 8'h00);
        check("post_rst_redirect", redirect_cnt, 0);
        do_jump(26'h9);
        check("trace_redirect", redirect_cnt, 1);
        check("trace_prev", prev_pc, 8'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the single-cycle MIPS datapath.
- Generalises PC width, immediate width and jump-field width.
- Adds a pipeline-ready stall input, jump-and-link with a hardware return-address stack (RAS), and return (pop) redirects.
- Feeds the instruction memory address and supplies the link value to the register-file write port.

Parameters:
PC_WIDTH, 8, width of PC and all targets (word-addressed)
IMM_WIDTH, 32, width of sign-extended branch offset input
JADDR_WIDTH, 26, width of jump address field (must be >= PC_WIDTH)
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
stall  input  1  hold PC and RAS this cycle
branch  input  1  conditional branch instruction
zero  input  1  ALU zero flag
imm  input  IMM_WIDTH  sign-extended branch offset (words)
jump  input  1  unconditional jump
jal  input  1  jump-and-link: jump and push return address
ret  input  1  return: redirect to popped RAS top
jump_addr  input  JADDR_WIDTH  jump target field
pc  output  PC_WIDTH  current PC (registered)
link_addr  output  PC_WIDTH  pc+1, combinational, for $ra write
ras_empty  output  1  RAS holds zero entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_ovf  output  1  sticky: push dropped the oldest entry
ras_unf  output  1  sticky: pop attempted on empty RAS

Behaviour:
- Reset: the design has one clock, clk, with a synchronous, active-low reset, rst_n, sampled at posedge clk. rst_n=0 at posedge sets pc=RESET_PC, clears RAS count and pointer, ras_ovf=0, ras_unf=0, ras_empty=1, ras_full=0. Reset overrides stall and all redirects, including mid-stall or mid-push.
- Update latency: 1 cycle. The next PC is computed combinationally and registered at posedge clk. All arithmetic is modulo 2^PC_WIDTH (wraps, no flag).
- Targets:
  - seq = pc+1
  - br = pc+1+imm[PC_WIDTH-1:0]
  - jt = jump_addr[PC_WIDTH-1:0]
  - rt = RAS top
- Next-PC priority:
  1. stall=1: pc, RAS and sticky flags unchanged; all other inputs ignored.
  2. ret=1: pc<=rt and pop. If the RAS is empty: pc<=seq, no pop, ras_unf<=1.
  3. jump=1 or jal=1: pc<=jt. jal additionally pushes seq.
  4. branch&zero: pc<=br.
  5. Otherwise: pc<=seq.
- ret and jal in the same cycle: pc<=rt, and the top entry is replaced by seq (count unchanged). If the RAS is empty: pc<=seq, push seq, ras_unf<=1.
- Push when full: circular overwrite of the oldest entry, count stays RAS_DEPTH, ras_ovf<=1.
- RAS structure: circular buffer with top pointer and count (0..RAS_DEPTH). ras_empty=(count==0), ras_full=(count==RAS_DEPTH), both derived from registered state.
- branch with zero=0 behaves as sequential. jump and jal both asserted behaves as jal.
- Sticky flags clear only on reset.

Optional Feature:
PC_SEQ_TRACE_EN
- Defined: adds output prev_pc [PC_WIDTH] (pc before the last non-stalled update, reset RESET_PC) and output redirect_cnt [16] (counts non-stalled updates where next pc != seq, wraps at 2^16, reset 0). Neither changes when stall=1.
- Undefined: ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 idle cycles with all controls 0 -> pc = 0,1,2,3,4; ras_empty=1.
- pc=5, branch=1, zero=1, imm=32'hFFFFFFFD -> pc=3. Repeat with zero=0 -> pc=6. pc=8'hFF idle -> pc=0 (wrap).
- pc=10, jal=1, jump_addr=26'h40 -> pc=8'h40, link_addr was 11, RAS top=11. Two idle cycles, then ret=1 -> pc=11, ras_empty=1.
- RAS_DEPTH=4: five jal from pc=1,2,3,4,5 (each target = pc+1) -> ras_full=1, ras_ovf=1. Five rets -> pcs 6,5,4,3, then pc+1 with ras_unf=1.
- stall=1 held 3 cycles with jal=1 and branch=1, zero=1 -> pc, RAS count and flags unchanged. Deassert stall -> jal takes effect.
- Mid-stall with 2 RAS entries, rst_n=0 for one cycle -> next posedge pc=RESET_PC, ras_empty=1, flags 0. With the macro defined: redirect_cnt=0 and prev_pc=RESET_PC.
